aes_axi_stream_mb: RTL
======================

Name: aes_axi_stream_mb

Overview:
- Next-generation AXI-Stream front end for aes_top. Accepts multi-block frames in a single stream transfer and supports ECB and CBC encryption.
- Caches the key across frames and double-buffers output, so block N+1 is encrypted while block N drains.
- Sits between the DMA MM2S/S2MM streams and the aes_top core instance; aes_top's ports are exposed at this boundary.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, slave data width; must equal C_M_AXIS_TDATA_WIDTH.
- C_M_AXIS_TDATA_WIDTH, 32, master data width.
- BLK_WORDS, 4, words per 128-bit block (128/width).
- KEY_WORDS, 4, key words (Nk); aes_key width = KEY_WORDS*width.

Ports:
- s00_axis_aclk  in  1  single clock for both stream sides and the engine.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tvalid/tready/tlast  in/out/in  1  slave handshake.
- s00_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  input words.
- s00_axis_tstrb  in  width/8  ignored.
- m00_axis_tvalid/tready/tlast  out/in/out  1  master handshake.
- m00_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  ciphertext words.
- m00_axis_tstrb  out  width/8  tied all-ones.
- aes_start  out  1  one-cycle engine start.
- aes_key_strobe  out  1  new key valid; asserted with aes_start.
- aes_key  out  KEY_WORDS*width  cached key, word0 in MSBs.
- aes_plaintext  out  128  engine input, held stable start..done.
- aes_ciphertext  in  128  engine output, valid with aes_done.
- aes_done  in  1  engine completion pulse.
- err_o  out  1  one-cycle pulse on frame-format error.

Behaviour:
- Frame layout, big-endian word order:
  - CMD word: bit0 KEY_LOAD, bit1 CBC, bit2 IV_LOAD.
  - Then KEY_WORDS key words if KEY_LOAD.
  - Then 4 IV words if IV_LOAD.
  - Then 1..n plaintext blocks of BLK_WORDS words; tlast on the final word.
- Reset (async assert; release synchronous to clock): all outputs 0, state CMD, key/IV/chain registers 0, both output slots empty.
- Input FSM: CMD -> KEY -> IV -> BLK -> WAIT -> BLK ... -> CMD. KEY/IV states are skipped when their bit is clear.
  - tready=1 in CMD, KEY, IV, and BLK while the word counter < BLK_WORDS.
  - On the 4th block word, enter WAIT with tready=0.
- WAIT:
  - Issue aes_start when the engine is idle AND at least one output slot is free.
  - Plaintext = block (ECB) or block XOR chain (CBC).
  - aes_key_strobe=1 on the first start after any key load, otherwise 0.
  - After start: return to BLK, or to CMD if that block carried tlast. The next block may be received while the engine runs.
- Engine completion: on aes_done, the ciphertext is written into the free output slot with its last flag. In CBC mode chain <= ciphertext in the same cycle.
- Chain register: loaded from IV when IV_LOAD; persists across frames when IV_LOAD=0 (CBC continuation). ECB never touches it.
- Output side:
  - Slots drain in write order, word0 first.
  - m00_axis_tvalid rises the cycle after the slot is written (latency 1 from aes_done).
  - tdata/tlast hold while tready=0.
  - tlast=1 only on word BLK_WORDS-1 of a last-flagged block.
  - The slot frees on its final handshake; back-to-back slots stream with no bubble.
- Error:
  - tlast on CMD, KEY, or IV words, or on a block word other than the 4th: discard partial data, pulse err_o, return to CMD.
  - A key or IV truncated this way is not committed.
  - Blocks already started complete and drain; the preceding emitted block carries no tlast.
- Simultaneous events:
  - aes_done and the final drain handshake in the same cycle: the write lands in the slot that is freeing; no loss.
  - CMD word accepted while the previous frame is still draining: allowed.
- Reset mid-operation: immediate return to reset state. The in-flight engine result is ignored, since aes_top shares the reset.
- Key cache: the key register persists across frames until the next KEY_LOAD.

Test Plan:
- FIPS-197 single block: CMD=0x1, key 000102..0f, pt 00112233445566778899aabbccddeeff with tlast -> out 69c4e0d8 6a7b0430 d8cdb780 70b4c55a; tlast on word 3; aes_key_strobe pulsed once.
- Key cache: second frame CMD=0x0 with the same pt -> identical ciphertext; aes_key_strobe stays 0.
- CBC, 3 blocks, NIST SP800-38A F.2.1: CMD=0x7, key 2b7e1516..., IV 00010203...0f -> 7649abac..., 5086cb9b..., 73bed6b8...; tlast only on the final word.
- Backpressure: m00_axis_tready toggling 1/0 plus 10-cycle stalls across a 4-block ECB frame -> tdata stable while stalled; no word lost or duplicated; s00_axis_tready drops once both slots fill.
- Truncated frame: tlast on block word 2 -> err_o single pulse; no output for the partial block; the next valid frame encrypts correctly.
- Async reset asserted mid-engine -> all outputs 0 the same cycle; a frame after release produces the FIPS-197 result.

Source files
------------

// File: rtl/aes_axi_stream_mb.sv
// AXI-Stream front end for aes_top: multi-block ECB/CBC frames, cached key,
// two output slots so the engine can run ahead of the drain side.
module aes_axi_stream_mb #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int BLK_WORDS            = 4,
  parameter int KEY_WORDS            = 4
) (
  input  logic                                 s00_axis_aclk,
  input  logic                                 s00_axis_aresetn,
  input  logic                                 s00_axis_tvalid,
  output logic                                 s00_axis_tready,
  input  logic                                 s00_axis_tlast,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]      s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]    s00_axis_tstrb,
  output logic                                 m00_axis_tvalid,
  input  logic                                 m00_axis_tready,
  output logic                                 m00_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]      m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]    m00_axis_tstrb,
  output logic                                 aes_start,
  output logic                                 aes_key_strobe,
  output logic [KEY_WORDS*C_S_AXIS_TDATA_WIDTH-1:0] aes_key,
  output logic [127:0]                         aes_plaintext,
  input  logic [127:0]                         aes_ciphertext,
  input  logic                                 aes_done,
  output logic                                 err_o
);

  // state | meaning
  // CMD   | waiting for the frame command word
  // KEY   | receiving key words
  // IV    | receiving IV words
  // BLK   | receiving plaintext block words
  // WAIT  | full block held, waiting for engine idle and a free output slot
  typedef enum logic [2:0] {S_CMD, S_KEY, S_IV, S_BLK, S_WAIT} state_t;

  localparam int DW    = C_S_AXIS_TDATA_WIDTH;
  localparam int BW    = BLK_WORDS * DW;
  localparam int KW    = KEY_WORDS * DW;
  localparam int MAXW  = (KEY_WORDS > BLK_WORDS) ? KEY_WORDS : BLK_WORDS;
  localparam int CNT_W = $clog2(MAXW) + 1;
  localparam int OI_W  = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WORDS - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_WORDS - 1);
  localparam logic [OI_W-1:0]  OUT_LAST = OI_W'(BLK_WORDS - 1);

  state_t state, state_nxt;
  logic             run;
  logic [CNT_W-1:0] cnt;
  logic             cmd_key, cmd_cbc, cmd_iv;
  logic [KW-1:0]    key_reg, key_sh;
  logic             key_new;
  logic [BW-1:0]    iv_reg, iv_sh, chain_reg, blk_buf, chain_src;
  logic             iv_pend, blk_last;
  logic             busy, fl_cbc, fl_last;
  logic [BW-1:0]    slot_data [2];
  logic [1:0]       slot_full, slot_last;
  logic             wr_ptr, rd_ptr;
  logic [OI_W-1:0]  out_idx;
  logic [DW-1:0]    out_words [BLK_WORDS];
  logic             s_ready, in_hs, go, frame_err, key_done, iv_done, blk_done, out_hs;
  logic             unused_tstrb;

  assign s00_axis_tready = s_ready;
  assign m00_axis_tstrb  = '1;
  assign aes_key         = key_reg;
  assign unused_tstrb    = ^s00_axis_tstrb;
  // A freshly loaded IV waits here so an earlier frame's CBC result cannot overwrite it.
  assign chain_src       = iv_pend ? iv_reg : chain_reg;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state <= S_CMD;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CMD:   if (in_hs && !s00_axis_tlast)
                 state_nxt = s00_axis_tdata[0] ? S_KEY : (s00_axis_tdata[2] ? S_IV : S_BLK);
      S_KEY:   if (frame_err)     state_nxt = S_CMD;
               else if (key_done) state_nxt = cmd_iv ? S_IV : S_BLK;
      S_IV:    if (frame_err)     state_nxt = S_CMD;
               else if (iv_done)  state_nxt = S_BLK;
      S_BLK:   if (frame_err)     state_nxt = S_CMD;
               else if (blk_done) state_nxt = S_WAIT;
      S_WAIT:  if (go)            state_nxt = blk_last ? S_CMD : S_BLK;
      default: state_nxt = S_CMD;
    endcase
  end

  always_comb begin
    s_ready   = run && (state != S_WAIT);
    in_hs     = s00_axis_tvalid && s_ready;
    go        = (state == S_WAIT) && !busy && !(&slot_full);
    frame_err = 1'b0;
    key_done  = 1'b0;
    iv_done   = 1'b0;
    blk_done  = 1'b0;
    case (state)
      S_CMD: frame_err = in_hs && s00_axis_tlast;
      S_KEY: begin
        frame_err = in_hs && s00_axis_tlast;
        key_done  = in_hs && !s00_axis_tlast && (cnt == KEY_LAST);
      end
      S_IV: begin
        frame_err = in_hs && s00_axis_tlast;
        iv_done   = in_hs && !s00_axis_tlast && (cnt == BLK_LAST);
      end
      S_BLK: begin
        frame_err = in_hs && s00_axis_tlast && (cnt != BLK_LAST);
        blk_done  = in_hs && (cnt == BLK_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < BLK_WORDS; i++)
      out_words[i] = slot_data[rd_ptr][BW-1-i*DW -: DW];
    m00_axis_tvalid = slot_full[rd_ptr];
    m00_axis_tdata  = out_words[out_idx];
    m00_axis_tlast  = slot_full[rd_ptr] && slot_last[rd_ptr] && (out_idx == OUT_LAST);
    out_hs          = m00_axis_tvalid && m00_axis_tready;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      run <= 1'b0;  cnt <= '0;  err_o <= 1'b0;
      cmd_key <= 1'b0;  cmd_cbc <= 1'b0;  cmd_iv <= 1'b0;
      key_reg <= '0;  key_sh <= '0;  key_new <= 1'b0;
      iv_reg <= '0;  iv_sh <= '0;  iv_pend <= 1'b0;  chain_reg <= '0;
      blk_buf <= '0;  blk_last <= 1'b0;
      busy <= 1'b0;  fl_cbc <= 1'b0;  fl_last <= 1'b0;
      aes_start <= 1'b0;  aes_key_strobe <= 1'b0;  aes_plaintext <= '0;
      slot_data[0] <= '0;  slot_data[1] <= '0;
      slot_full <= '0;  slot_last <= '0;  wr_ptr <= 1'b0;  rd_ptr <= 1'b0;  out_idx <= '0;
    end else begin
      run            <= 1'b1;
      err_o          <= frame_err;
      aes_start      <= 1'b0;
      aes_key_strobe <= 1'b0;
      if (in_hs) begin
        case (state)
          S_CMD: begin
            if (!s00_axis_tlast) {cmd_iv, cmd_cbc, cmd_key} <= s00_axis_tdata[2:0];
            cnt <= '0;
          end
          S_KEY: begin key_sh  <= {key_sh[KW-DW-1:0], s00_axis_tdata};  cnt <= cnt + 1'b1; end
          S_IV:  begin iv_sh   <= {iv_sh[BW-DW-1:0], s00_axis_tdata};   cnt <= cnt + 1'b1; end
          S_BLK: begin blk_buf <= {blk_buf[BW-DW-1:0], s00_axis_tdata}; cnt <= cnt + 1'b1; end
          default: ;
        endcase
      end
      if (key_done) begin
        key_reg <= {key_sh[KW-DW-1:0], s00_axis_tdata};
        key_new <= 1'b1;
        cnt     <= '0;
      end
      if (iv_done) begin
        iv_reg  <= {iv_sh[BW-DW-1:0], s00_axis_tdata};
        iv_pend <= 1'b1;
        cnt     <= '0;
      end
      if (blk_done)  blk_last <= s00_axis_tlast;
      if (frame_err) cnt <= '0;
      if (go) begin
        aes_start      <= 1'b1;
        aes_key_strobe <= key_new;
        key_new        <= 1'b0;
        aes_plaintext  <= cmd_cbc ? (blk_buf ^ chain_src) : blk_buf;
        busy           <= 1'b1;
        fl_cbc         <= cmd_cbc;
        fl_last        <= blk_last;
        cnt            <= '0;
        if (iv_pend) begin
          chain_reg <= iv_reg;
          iv_pend   <= 1'b0;
        end
      end
      if (out_hs) begin
        if (out_idx == OUT_LAST) begin
          slot_full[rd_ptr] <= 1'b0;
          rd_ptr            <= ~rd_ptr;
          out_idx           <= '0;
        end else begin
          out_idx <= out_idx + 1'b1;
        end
      end
      // Placed after the drain so a write into a slot freeing this cycle wins.
      if (aes_done) begin
        busy              <= 1'b0;
        slot_data[wr_ptr] <= aes_ciphertext;
        slot_last[wr_ptr] <= fl_last;
        slot_full[wr_ptr] <= 1'b1;
        wr_ptr            <= ~wr_ptr;
        if (fl_cbc) chain_reg <= aes_ciphertext;
      end
    end
  end

endmodule
